// File: rtl/lane_arbiter.sv
// Four-lane round-robin burst arbiter with a single registered output slot.
// Optional per-lane transfer counters: define LANE_ARBITER_STATS_EN.
module lane_arbiter #(
    parameter int BURST_LEN = 4,
    parameter int DATA_W    = 8
) (
    input  logic              clk_f,
    input  logic              reset_L,
    input  logic [DATA_W-1:0] data_in_0,
    input  logic [DATA_W-1:0] data_in_1,
    input  logic [DATA_W-1:0] data_in_2,
    input  logic [DATA_W-1:0] data_in_3,
    input  logic              valid_in_0,
    input  logic              valid_in_1,
    input  logic              valid_in_2,
    input  logic              valid_in_3,
    output logic              ready_0,
    output logic              ready_1,
    output logic              ready_2,
    output logic              ready_3,
    input  logic              ready_out,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic [1:0]        lane_out
`ifdef LANE_ARBITER_STATS_EN
    ,
    output logic [15:0]       beat_cnt_0,
    output logic [15:0]       beat_cnt_1,
    output logic [15:0]       beat_cnt_2,
    output logic [15:0]       beat_cnt_3
`endif
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t                  state;
    logic [1:0]              ptr;
    logic [1:0]              g;
    logic [3:0]              cnt;
    logic [3:0]              vin;
    logic [3:0]              rdy;
    logic [3:0][DATA_W-1:0]  din;
    logic [3:0]              rot;
    logic [1:0]              off;
    logic [1:0]              pick;
    logic                    slot_free;
    logic                    xfer;
    logic                    last_beat;

    assign vin = {valid_in_3, valid_in_2, valid_in_1, valid_in_0};
    assign din = {data_in_3, data_in_2, data_in_1, data_in_0};

    // Rotate requests so bit 0 is the lane at ptr; the lowest set bit wins.
    always_comb begin
        rot = 4'({vin, vin} >> ptr);
        off = 2'd3;
        if (rot[0])      off = 2'd0;
        else if (rot[1]) off = 2'd1;
        else if (rot[2]) off = 2'd2;
    end
    assign pick = ptr + off;

    assign slot_free = !valid_out || ready_out;
    assign rdy       = (state == GRANT && slot_free) ? (4'b0001 << g) : 4'b0000;
    assign xfer      = (state == GRANT) && vin[g] && slot_free;
    assign last_beat = (cnt == 4'(BURST_LEN - 1));

    assign ready_0 = rdy[0];
    assign ready_1 = rdy[1];
    assign ready_2 = rdy[2];
    assign ready_3 = rdy[3];

    always_ff @(posedge clk_f or negedge reset_L) begin
        if (!reset_L) begin
            state     <= IDLE;
            ptr       <= 2'd0;
            g         <= 2'd0;
            cnt       <= 4'd0;
            valid_out <= 1'b0;
            data_out  <= '0;
            lane_out  <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (|vin) begin
                        state <= GRANT;
                        g     <= pick;
                        cnt   <= 4'd0;
                    end
                end
                GRANT: begin
                    // A dropped request ends the burst early; ptr moves past g either way.
                    if (!vin[g] || (xfer && last_beat)) begin
                        state <= IDLE;
                        ptr   <= g + 2'd1;
                    end else if (xfer) begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (xfer) begin
                data_out  <= din[g];
                lane_out  <= g;
                valid_out <= 1'b1;
            end else if (slot_free) begin
                valid_out <= 1'b0;
            end
        end
    end

`ifdef LANE_ARBITER_STATS_EN
    logic [3:0][15:0] beat_cnt;

    always_ff @(posedge clk_f or negedge reset_L) begin
        if (!reset_L) begin
            beat_cnt <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (xfer && g == 2'(i)) beat_cnt[i] <= beat_cnt[i] + 16'd1;
            end
        end
    end

    assign beat_cnt_0 = beat_cnt[0];
    assign beat_cnt_1 = beat_cnt[1];
    assign beat_cnt_2 = beat_cnt[2];
    assign beat_cnt_3 = beat_cnt[3];
`endif

endmodule

// File: tb/tb_lane_arbiter.sv
// Cycle-accurate scoreboard bench for lane_arbiter (BURST_LEN=4, DATA_W=8).
module tb_lane_arbiter;

    localparam int DW = 8;

    typedef struct {
        bit       vld;
        bit [1:0] lane;
        bit [7:0] data;
        bit       ro;
        bit       rchk;
        bit [3:0] rdy;
    } exp_t;

    logic          clk_f = 1'b0;
    logic          reset_L;
    logic [3:0]    vin;
    logic [DW-1:0] din [4];
    logic          ready_out;
    logic [3:0]    rdy;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic [1:0]    lane_out;
`ifdef LANE_ARBITER_STATS_EN
    logic [15:0]   bc0, bc1, bc2, bc3;
`endif

    exp_t          exp_q[$];
    int            idx  [4];
    int            lim  [4];
    logic [7:0]    base [4];
    int            n_tests = 0;
    int            n_fail  = 0;

    always #5 clk_f = ~clk_f;

    lane_arbiter #(.BURST_LEN(4), .DATA_W(DW)) dut (
        .clk_f     (clk_f),
        .reset_L   (reset_L),
        .data_in_0 (din[0]),
        .data_in_1 (din[1]),
        .data_in_2 (din[2]),
        .data_in_3 (din[3]),
        .valid_in_0(vin[0]),
        .valid_in_1(vin[1]),
        .valid_in_2(vin[2]),
        .valid_in_3(vin[3]),
        .ready_0   (rdy[0]),
        .ready_1   (rdy[1]),
        .ready_2   (rdy[2]),
        .ready_3   (rdy[3]),
        .ready_out (ready_out),
        .data_out  (data_out),
        .valid_out (valid_out),
        .lane_out  (lane_out)
`ifdef LANE_ARBITER_STATS_EN
        ,
        .beat_cnt_0(bc0),
        .beat_cnt_1(bc1),
        .beat_cnt_2(bc2),
        .beat_cnt_3(bc3)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, expv);
        end
    endtask

    function automatic void push(input bit vld, input bit [1:0] lane, input bit [7:0] data,
                                 input bit ro, input bit rchk, input bit [3:0] r);
        exp_t e;
        e.vld = vld; e.lane = lane; e.data = data;
        e.ro = ro; e.rchk = rchk; e.rdy = r;
        exp_q.push_back(e);
    endfunction

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            vin[i] = (idx[i] < lim[i]);
            din[i] = base[i] + 8'(idx[i]);
        end
    endtask

    // Drive, check ready before the edge, then check the registered output after it.
    task automatic cycle();
        exp_t       e;
        logic [3:0] xf;
        bit         have;
        have = (exp_q.size() > 0);
        if (have) begin
            e = exp_q.pop_front();
            ready_out = e.ro;
        end else begin
            ready_out = 1'b1;
        end
        drive();
        #1;
        if (have && e.rchk) chk("ready", 32'(rdy), 32'(e.rdy));
        xf = vin & rdy;
        @(posedge clk_f);
        #1;
        for (int i = 0; i < 4; i++) if (xf[i]) idx[i]++;
        if (have) begin
            chk("valid_out", 32'(valid_out), 32'(e.vld));
            if (e.vld) chk("lane_data", 32'({lane_out, data_out}), 32'({e.lane, e.data}));
        end
    endtask

    task automatic run();
        while (exp_q.size() > 0) cycle();
    endtask

    task automatic do_reset();
        reset_L   = 1'b0;
        ready_out = 1'b1;
        for (int i = 0; i < 4; i++) begin
            idx[i] = 0; lim[i] = 0; base[i] = 8'h00;
        end
        drive();
        repeat (2) @(posedge clk_f);
        #1;
        reset_L = 1'b1;
    endtask

    initial begin
        // Reset with every lane requesting
        reset_L   = 1'b0;
        ready_out = 1'b1;
        for (int i = 0; i < 4; i++) begin
            idx[i] = 0; lim[i] = 4; base[i] = 8'hA0;
        end
        drive();
        @(posedge clk_f);
        #1;
        chk("rst_valid", 32'(valid_out), 32'd0);
        chk("rst_data",  32'(data_out),  32'd0);
        chk("rst_lane",  32'(lane_out),  32'd0);
        chk("rst_ready", 32'(rdy),       32'd0);

        // Single lane 1 stream: two bursts separated by one idle cycle
        do_reset();
        lim[1] = 8; base[1] = 8'h10;
        push(0, 2'd0, 8'h00, 1, 1, 4'b0000);
        for (int j = 0; j < 4; j++) push(1, 2'd1, 8'(8'h10 + j), 1, j == 0, 4'b0010);
        push(0, 2'd0, 8'h00, 1, 1, 4'b0000);
        for (int j = 4; j < 8; j++) push(1, 2'd1, 8'(8'h10 + j), 1, j == 4, 4'b0010);
        push(0, 2'd0, 8'h00, 1, 0, 4'b0000);
        run();

        // Fairness: all lanes busy, grant order 0,1,2,3,0
        do_reset();
        for (int i = 0; i < 4; i++) begin
            lim[i] = 16; base[i] = 8'(8'h80 + 16 * i);
        end
        for (int b = 0; b < 5; b++) begin
            push(0, 2'd0, 8'h00, 1, 1, 4'b0000);
            for (int j = 0; j < 4; j++)
                push(1, 2'(b % 4), 8'(base[b % 4] + 8'((b / 4) * 4 + j)), 1, j == 0,
                     4'(4'b0001 << (b % 4)));
        end
        run();

        // Backpressure on lane 2 after its 2nd beat
        do_reset();
        lim[2] = 8; base[2] = 8'h20;
        push(0, 2'd0, 8'h00, 1, 0, 4'b0000);
        push(1, 2'd2, 8'h20, 1, 1, 4'b0100);
        push(1, 2'd2, 8'h21, 1, 0, 4'b0000);
        repeat (3) push(1, 2'd2, 8'h21, 0, 1, 4'b0000);
        push(1, 2'd2, 8'h22, 1, 1, 4'b0100);
        push(1, 2'd2, 8'h23, 1, 1, 4'b0100);
        push(0, 2'd0, 8'h00, 1, 0, 4'b0000);
        run();

        // Reset in the middle of a lane-3 burst
        do_reset();
        lim[3] = 8; base[3] = 8'h30;
        push(0, 2'd0, 8'h00, 1, 0, 4'b0000);
        push(1, 2'd3, 8'h30, 1, 1, 4'b1000);
        push(1, 2'd3, 8'h31, 1, 0, 4'b0000);
        run();
        reset_L   = 1'b0;
        ready_out = 1'b1;
        for (int i = 0; i < 4; i++) lim[i] = 16;
        drive();
        #1;
        chk("mid_rst_valid", 32'(valid_out), 32'd0);
        chk("mid_rst_data",  32'(data_out),  32'd0);
        chk("mid_rst_lane",  32'(lane_out),  32'd0);
        chk("mid_rst_ready", 32'(rdy),       32'd0);
        @(posedge clk_f);
        #1;
        chk("mid_rst_hold", 32'({valid_out, rdy}), 32'd0);
        for (int i = 0; i < 4; i++) begin
            idx[i] = 0; lim[i] = 0;
        end
        lim[0] = 8; base[0] = 8'h40;
        lim[3] = 8; base[3] = 8'h30;
        reset_L = 1'b1;
        push(0, 2'd0, 8'h00, 1, 1, 4'b0000);
        push(1, 2'd0, 8'h40, 1, 1, 4'b0001);
        push(1, 2'd0, 8'h41, 1, 0, 4'b0000);
        run();

`ifdef LANE_ARBITER_STATS_EN
        do_reset();
        chk("stats_rst", 32'({bc0, bc1}) | 32'({bc2, bc3}), 32'd0);
        lim[2] = 10; base[2] = 8'h50;
        repeat (16) cycle();
        chk("beat_cnt_0", 32'(bc0), 32'd0);
        chk("beat_cnt_1", 32'(bc1), 32'd0);
        chk("beat_cnt_2", 32'(bc2), 32'd10);
        chk("beat_cnt_3", 32'(bc3), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
